// File: rtl/load_resp_align_pkg.sv
// Shared CPU load/store type definitions plus the load metadata entry layout.
// LOAD_LR_MERGE_EN adds the LWL/LWR merge fields to the metadata entry.
package load_resp_align_pkg;

  typedef struct packed {
    logic       sign;
    logic [1:0] size;         // 00 byte, 01 half, 10 word
    logic [1:0] LeftOrRight;  // 00 normal, 01 LWL, 10 LWR
  } LoadType;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] LeftOrRight;
  } StoreType;

  localparam LoadType LOADTYPE_LW  = '{sign: 1'b0, size: 2'b10, LeftOrRight: 2'b00};
  localparam LoadType LOADTYPE_LH  = '{sign: 1'b1, size: 2'b01, LeftOrRight: 2'b00};
  localparam LoadType LOADTYPE_LHU = '{sign: 1'b0, size: 2'b01, LeftOrRight: 2'b00};
  localparam LoadType LOADTYPE_LB  = '{sign: 1'b1, size: 2'b00, LeftOrRight: 2'b00};
  localparam LoadType LOADTYPE_LBU = '{sign: 1'b0, size: 2'b00, LeftOrRight: 2'b00};
  localparam LoadType LOADTYPE_LWL = '{sign: 1'b0, size: 2'b10, LeftOrRight: 2'b01};
  localparam LoadType LOADTYPE_LWR = '{sign: 1'b0, size: 2'b10, LeftOrRight: 2'b10};

  localparam StoreType STORETYPE_SW = '{size: 2'b10, LeftOrRight: 2'b00};
  localparam StoreType STORETYPE_SH = '{size: 2'b01, LeftOrRight: 2'b00};
  localparam StoreType STORETYPE_SB = '{size: 2'b00, LeftOrRight: 2'b00};

  localparam logic [1:0] LR_NONE  = 2'b00;
  localparam logic [1:0] LR_LEFT  = 2'b01;
  localparam logic [1:0] LR_RIGHT = 2'b10;

  typedef struct packed {
    logic [1:0]  addr;
    logic        sign;
    logic [1:0]  size;
`ifdef LOAD_LR_MERGE_EN
    logic [1:0]  lr;
    logic [31:0] rt;
`endif
  } meta_t;

endpackage

// File: rtl/load_data_extract.sv
// Combinational byte/half/word extraction and LWL/LWR merge of a load word.
// The merge path exists only when LOAD_LR_MERGE_EN is defined.
module load_data_extract
  import load_resp_align_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic        sign,
  input  logic [1:0]  size,
`ifdef LOAD_LR_MERGE_EN
  input  logic [1:0]  lr,
  input  logic [31:0] rt,
`endif
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      2'b00:   data = {{24{sign & byte_sel[7]}}, byte_sel};
      2'b01:   data = {{16{sign & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase

`ifdef LOAD_LR_MERGE_EN
    // Unaligned word halves: new bytes land at the top (LWL) or bottom (LWR).
    if (lr == LR_LEFT) begin
      case (addr)
        2'd0: data = {rdata[7:0],  rt[23:0]};
        2'd1: data = {rdata[15:0], rt[15:0]};
        2'd2: data = {rdata[23:0], rt[7:0]};
        default: data = rdata;
      endcase
    end else if (lr == LR_RIGHT) begin
      case (addr)
        2'd0: data = rdata;
        2'd1: data = {rt[31:24], rdata[31:8]};
        2'd2: data = {rt[31:16], rdata[31:16]};
        default: data = {rt[31:8], rdata[31:24]};
      endcase
    end
`endif
  end

endmodule

// File: rtl/load_resp_align.sv
// Load response aligner: metadata FIFO of outstanding loads plus one output register.
// Define LOAD_LR_MERGE_EN to enable the LWL/LWR merge with per-entry rt storage.
module load_resp_align
  import load_resp_align_pkg::*;
#(
  parameter int META_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_addr,
  input  LoadType     req_type,
  input  logic [31:0] req_rt,
  input  logic        flush,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [31:0] resp_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic        resp_err
);

  localparam int PW = $clog2(META_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(META_DEPTH);

  meta_t                 mem [META_DEPTH];
  logic [META_DEPTH-1:0] killed;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic                  full, empty, push, pop, resp_fire;
  meta_t                 req_meta, head;
  logic                  head_killed;
  logic [31:0]           result;

  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign req_ready  = !full;
  assign resp_ready = !wb_valid || wb_ready;
  assign push       = req_valid && !full;
  assign resp_fire  = resp_valid && resp_ready;
  assign pop        = resp_fire && !empty;

  assign head        = mem[rd_ptr];
  assign head_killed = killed[rd_ptr];

  always_comb begin
    req_meta      = '0;
    req_meta.addr = req_addr;
    req_meta.sign = req_type.sign;
    req_meta.size = req_type.size;
`ifdef LOAD_LR_MERGE_EN
    req_meta.lr   = req_type.LeftOrRight;
    req_meta.rt   = req_rt;
`endif
  end

`ifndef LOAD_LR_MERGE_EN
  logic lr_rt_unused;
  assign lr_rt_unused = ^{req_type.LeftOrRight, req_rt};
`endif

  // Entry payload needs no reset; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_meta;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      killed   <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      resp_err <= 1'b0;
    end else begin
      // A push alongside flush overrides the kill for its own slot.
      if (flush) killed <= '1;
      if (push) begin
        killed[wr_ptr] <= 1'b0;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (resp_fire && empty) resp_err <= 1'b1;

      if (flush)                    wb_valid <= 1'b0;
      else if (pop && !head_killed) wb_valid <= 1'b1;
      else if (wb_ready)            wb_valid <= 1'b0;

      if (pop && !head_killed && !flush) wb_data <= result;
    end
  end

  load_data_extract u_extract (
    .addr  (head.addr),
    .sign  (head.sign),
    .size  (head.size),
`ifdef LOAD_LR_MERGE_EN
    .lr    (head.lr),
    .rt    (head.rt),
`endif
    .rdata (resp_rdata),
    .data  (result)
  );

endmodule

// File: tb/tb_load_resp_align.sv
// Directed bench for load_resp_align: extraction, ordering, back-pressure, flush, reset.
module tb_load_resp_align;
  import load_resp_align_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, req_valid, req_ready, flush, resp_valid, resp_ready;
  logic        wb_valid, wb_ready, resp_err;
  logic [1:0]  req_addr;
  LoadType     req_type;
  logic [31:0] req_rt, resp_rdata, wb_data;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  load_resp_align #(.META_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_type(req_type), .req_rt(req_rt), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .resp_err(resp_err)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [1:0] a, input LoadType t, input logic [31:0] rt);
    req_valid = 1'b1; req_addr = a; req_type = t; req_rt = rt;
    step();
    req_valid = 1'b0;
  endtask

  task automatic load1(input string tag, input logic [1:0] a, input LoadType t,
                       input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
    push_req(a, t, rt);
    resp_valid = 1'b1; resp_rdata = rd;
    step();
    resp_valid = 1'b0;
    chk({tag, "_vld"}, 32'(wb_valid), 32'd1);
    chk(tag, wb_data, exp);
    step();
    chk({tag, "_drain"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_type = LOADTYPE_LW; req_rt = '0;
    flush = 1'b0; resp_valid = 1'b0; resp_rdata = '0; wb_ready = 1'b1;
    step(); step();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_ready", 32'(resp_ready), 32'd1);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    resetn = 1'b1;
    step();

    load1("lb_a3",  2'd3, LOADTYPE_LB,  32'h0, 32'h80AA5511, 32'hFFFFFF80);
    load1("lbu_a3", 2'd3, LOADTYPE_LBU, 32'h0, 32'h80AA5511, 32'h00000080);
    load1("lb_a1",  2'd1, LOADTYPE_LB,  32'h0, 32'h80AA5511, 32'h00000055);
    load1("lh_a1",  2'd1, LOADTYPE_LH,  32'h0, 32'h80AA5511, 32'h00005511);
    load1("lh_a2",  2'd2, LOADTYPE_LH,  32'h0, 32'h80AA5511, 32'hFFFF80AA);
    load1("lhu_a3", 2'd3, LOADTYPE_LHU, 32'h0, 32'h80AA5511, 32'h000080AA);
    load1("lw",     2'd0, LOADTYPE_LW,  32'h0, 32'h80AA5511, 32'h80AA5511);
`ifdef LOAD_LR_MERGE_EN
    load1("lwl_a1", 2'd1, LOADTYPE_LWL, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD);
    load1("lwr_a2", 2'd2, LOADTYPE_LWR, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122);
    load1("lwl_a0", 2'd0, LOADTYPE_LWL, 32'hAABBCCDD, 32'h11223344, 32'h44BBCCDD);
    load1("lwr_a3", 2'd3, LOADTYPE_LWR, 32'hAABBCCDD, 32'h11223344, 32'hAABBCC11);
`else
    load1("lwl_a1", 2'd1, LOADTYPE_LWL, 32'hAABBCCDD, 32'h11223344, 32'h11223344);
    load1("lwr_a2", 2'd2, LOADTYPE_LWR, 32'hAABBCCDD, 32'h11223344, 32'h11223344);
`endif

    // Fill to depth, third request refused, including while a pop happens.
    req_valid = 1'b1; req_addr = 2'd0; req_type = LOADTYPE_LW;
    step();
    chk("fill1_ready", 32'(req_ready), 32'd1);
    req_type = LOADTYPE_LB;
    step();
    chk("fill2_ready", 32'(req_ready), 32'd0);
    req_type = LOADTYPE_LW;
    step();
    chk("fill3_ready", 32'(req_ready), 32'd0);
    resp_valid = 1'b1; resp_rdata = 32'h12345678;
    step();
    req_valid = 1'b0;
    chk("ord1_vld", 32'(wb_valid), 32'd1);
    chk("ord1_data", wb_data, 32'h12345678);
    chk("ord1_ready", 32'(req_ready), 32'd1);
    resp_rdata = 32'h000000F0;
    step();
    resp_valid = 1'b0;
    chk("ord2_vld", 32'(wb_valid), 32'd1);
    chk("ord2_data", wb_data, 32'hFFFFFFF0);
    step();
    chk("ord_drain", 32'(wb_valid), 32'd0);
    chk("ord_err", 32'(resp_err), 32'd0);

    // Writeback back-pressure.
    push_req(2'd0, LOADTYPE_LW, 32'h0);
    push_req(2'd0, LOADTYPE_LW, 32'h0);
    wb_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'hCAFE0001;
    step();
    chk("bp_vld", 32'(wb_valid), 32'd1);
    chk("bp_data", wb_data, 32'hCAFE0001);
    resp_rdata = 32'hCAFE0002;
    for (int i = 0; i < 3; i++) begin
      chk("bp_resp_ready", 32'(resp_ready), 32'd0);
      chk("bp_hold_data", wb_data, 32'hCAFE0001);
      chk("bp_hold_vld", 32'(wb_valid), 32'd1);
      step();
    end
    wb_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(resp_ready), 32'd1);
    step();
    resp_valid = 1'b0;
    chk("bp_next_vld", 32'(wb_valid), 32'd1);
    chk("bp_next_data", wb_data, 32'hCAFE0002);
    step();
    chk("bp_drain", 32'(wb_valid), 32'd0);

    // Flush clears a pending result.
    push_req(2'd0, LOADTYPE_LW, 32'h0);
    wb_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h55555555;
    step();
    resp_valid = 1'b0;
    chk("fl_pend_vld", 32'(wb_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; wb_ready = 1'b1;
    chk("fl_pend_clr", 32'(wb_valid), 32'd0);

    // Flush with two outstanding, then their responses drain silently.
    push_req(2'd0, LOADTYPE_LW, 32'h0);
    push_req(2'd0, LOADTYPE_LW, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_full_ready", 32'(req_ready), 32'd0);
    resp_valid = 1'b1; resp_rdata = 32'h0BADF00D;
    step();
    chk("fl_r1_vld", 32'(wb_valid), 32'd0);
    step();
    resp_valid = 1'b0;
    chk("fl_r2_vld", 32'(wb_valid), 32'd0);
    chk("fl_err", 32'(resp_err), 32'd0);
    chk("fl_empty_ready", 32'(req_ready), 32'd1);
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    chk("orphan_vld", 32'(wb_valid), 32'd0);
    chk("orphan_err", 32'(resp_err), 32'd1);
    step();
    chk("orphan_err_sticky", 32'(resp_err), 32'd1);

    // Push concurrent with flush survives; older entry is killed.
    push_req(2'd0, LOADTYPE_LW, 32'h0);
    req_valid = 1'b1; req_addr = 2'd0; req_type = LOADTYPE_LW; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    resp_valid = 1'b1; resp_rdata = 32'h11111111;
    step();
    chk("flpush_old_vld", 32'(wb_valid), 32'd0);
    resp_rdata = 32'h22222222;
    step();
    resp_valid = 1'b0;
    chk("flpush_new_vld", 32'(wb_valid), 32'd1);
    chk("flpush_new_data", wb_data, 32'h22222222);
    step();

    // Reset mid-stream.
    push_req(2'd0, LOADTYPE_LW, 32'h0);
    push_req(2'd0, LOADTYPE_LW, 32'h0);
    resp_valid = 1'b1; resp_rdata = 32'h33333333;
    step();
    resp_valid = 1'b0;
    chk("mid_vld", 32'(wb_valid), 32'd1);
    resetn = 1'b0;
    step();
    chk("mrst_vld", 32'(wb_valid), 32'd0);
    chk("mrst_req_ready", 32'(req_ready), 32'd1);
    chk("mrst_err", 32'(resp_err), 32'd0);
    chk("mrst_data", wb_data, 32'd0);
    resetn = 1'b1;
    resp_valid = 1'b1; resp_rdata = 32'h44444444;
    step();
    resp_valid = 1'b0;
    chk("mrst_dropped_vld", 32'(wb_valid), 32'd0);
    chk("mrst_dropped_err", 32'(resp_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_resp_align.md
LOAD_RESP_ALIGN -- requirements
Module: load_resp_align

Interface
REQ-001 SHALL have parameter META_DEPTH, default 2, the number of outstanding load requests tracked (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  load issued to DCache this cycle.
REQ-005 SHALL have port req_ready  output  1  metadata FIFO can accept a request.
REQ-006 SHALL have port req_addr  input  2  byte offset, ALU result [1:0].
REQ-007 SHALL have port req_type  input  LoadType  sign, size and LeftOrRight of the load.
REQ-008 SHALL have port req_rt  input  32  old rt value, for the LWL/LWR merge.
REQ-009 SHALL have port flush  input  1  kill all outstanding loads and any pending output.
REQ-010 SHALL have port resp_valid  input  1  DCache read data is valid.
REQ-011 SHALL have port resp_ready  output  1  block accepts the read data.
REQ-012 SHALL have port resp_rdata  input  32  raw aligned word from the DCache.
REQ-013 SHALL have port wb_valid  output  1  aligned load result is available.
REQ-014 SHALL have port wb_ready  input  1  writeback consumes the result.
REQ-015 SHALL have port wb_data  output  32  extended or merged result.
REQ-016 SHALL have port resp_err  output  1  sticky flag: a response arrived with no outstanding request.

Function
REQ-017 SHALL push {req_addr, req_type, req_rt, killed=0} into the metadata FIFO when req_valid && req_ready.
REQ-018 SHALL drive req_ready = !full; a push and a pop in the same cycle while full SHALL still be refused.
REQ-019 SHALL drive resp_ready = !wb_valid || wb_ready, so the output register behaves as a pass-through pipeline stage.
REQ-020 SHALL pop the FIFO head and compute the result from it when resp_valid && resp_ready && !empty.
REQ-021 SHALL provide latency of exactly 1 cycle: a response accepted in cycle N makes wb_valid=1 in cycle N+1.
REQ-022 SHALL hold wb_valid and wb_data stable until wb_ready; back-to-back responses at full throughput SHALL be supported.
REQ-023 SHALL form LB/LBU as the byte at offset a, sign-extended if sign=1 and zero-extended otherwise.
REQ-024 SHALL form LH/LHU as the halfword selected by a[1], extended per sign; a[0] is ignored.
REQ-025 SHALL form LW as rdata unchanged.
REQ-026 SHALL form LWL for a = 0, 1, 2, 3 as, respectively, {rdata[7:0],rt[23:0]}, {rdata[15:0],rt[15:0]}, {rdata[23:0],rt[7:0]}, rdata.
REQ-027 SHALL form LWR for a = 0, 1, 2, 3 as, respectively, rdata, {rt[31:24],rdata[31:8]}, {rt[31:16],rdata[31:16]}, {rt[31:8],rdata[31:24]}.
REQ-028 SHALL, on flush, clear wb_valid next cycle and set killed=1 on every FIFO entry.
REQ-029 SHALL pop killed entries on their responses without setting wb_valid; FIFO occupancy is preserved until those responses drain.
REQ-030 SHALL treat a request pushed in the same cycle as flush as not killed.
REQ-031 SHALL, on resp_valid with an empty FIFO, accept and discard the response and set resp_err=1 until reset.
REQ-032 SHALL generate pointers with wrap-around modulo META_DEPTH and full/empty from an extra-bit count.

Reset
REQ-033 SHALL, while resetn=0 at a rising edge, set FIFO empty, wb_valid=0, wb_data=0 and resp_err=0.
REQ-034 SHALL drop in-flight entries on reset mid-operation, with no output afterwards for them.

Configuration
REQ-035 SHALL, with LOAD_LR_MERGE_EN defined, implement REQ-026 and REQ-027 and store req_rt per entry.
REQ-036 SHALL, without LOAD_LR_MERGE_EN, omit rt storage and treat LeftOrRight as 2'b00 (normal load per size).

Structure
REQ-037 SHALL take the LoadType struct (sign, size[1:0], LeftOrRight[1:0]) and the LOADTYPE_LW/LH/LB constants from the shared CPU defines package, alongside StoreType.
REQ-038 SHALL place the combinational extract/merge in one sub-module, load_data_extract; the FIFO and output register stay in load_resp_align.

Verification
REQ-039 SHALL verify: LB a=3, rdata=0x80AA5511 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-040 SHALL verify: LWL a=1, rdata=0x11223344, rt=0xAABBCCDD -> 0x3344CCDD; LWR a=2 same -> 0xAABB1122.
REQ-041 SHALL verify: 3 requests with META_DEPTH=2 -> req_ready=0 after 2; 2 responses -> 2 results in order, each 1 cycle after acceptance.
REQ-042 SHALL verify: wb_ready held 0 for 3 cycles with wb_valid=1 -> resp_ready=0, wb_data stable; released -> next result the following cycle.
REQ-043 SHALL verify: flush with 2 outstanding, then 2 responses -> no wb_valid, FIFO empty, resp_err=0; an extra response -> resp_err=1.
REQ-044 SHALL verify: resetn=0 mid-stream -> next cycle wb_valid=0, req_ready=1, resp_err=0.
